// File: rtl/mux_pkg.sv
// ============================================================================
// Module   : mux_pkg
// Brief    : Shared types and helpers for the round-robin stream multiplexer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mux_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   function automatic int mux_sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker; first requester at or after ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int N     = 4,
   localparam int SEL_W = mux_sel_w(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [SEL_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_valid
);

   logic [SEL_W-1:0] w_hi_idx;
   logic             w_hi_vld;
   logic [SEL_W-1:0] w_lo_idx;
   logic             w_lo_vld;

   // Split the ring at ptr: lowest requester >= ptr wins, else lowest below it.
   // No modular addition is needed, so non-power-of-2 N wraps correctly.
   always_comb begin
      w_hi_idx = '0;
      w_hi_vld = 1'b0;
      w_lo_idx = '0;
      w_lo_vld = 1'b0;
      for (int c = N - 1; c >= 0; c--) begin
         if (i_req[c]) begin
            if (SEL_W'(c) >= i_ptr) begin
               w_hi_vld = 1'b1;
               w_hi_idx = SEL_W'(c);
            end else begin
               w_lo_vld = 1'b1;
               w_lo_idx = SEL_W'(c);
            end
         end
      end
   end

   assign o_valid = w_hi_vld | w_lo_vld;
   assign o_idx   = w_hi_vld ? w_hi_idx : w_lo_idx;
   assign o_grant = o_valid ? (N'(1) << o_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/mux_rr_stream.sv
// ============================================================================
// Module   : mux_rr_stream
// Brief    : Registered N:1 stream mux, round-robin with packet lock.
//            Optional MUX_FORCE_SEL_EN adds force_en/force_sel override in IDLE.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_rr_stream
   import mux_pkg::*;
#(
   parameter  int WIDTH = 64,
   parameter  int N     = 4,
   localparam int SEL_W = mux_sel_w(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_last,
   output logic [SEL_W-1:0]     out_sel,
`ifdef MUX_FORCE_SEL_EN
   input  logic                 force_en,
   input  logic [SEL_W-1:0]     force_sel,
`endif
   output logic                 busy
);

   localparam logic [SEL_W-1:0] c_last_idx = SEL_W'(N - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] w_ptr_nxt;
   logic [SEL_W-1:0] r_lock_ch;
   logic [SEL_W-1:0] w_lock_nxt;

   logic [N-1:0]     w_arb_grant;
   logic [SEL_W-1:0] w_arb_idx;
   logic             w_arb_vld;

   logic [SEL_W-1:0] w_g;
   logic             w_g_vld;
   logic [N-1:0]     w_g_oh;
   logic [SEL_W-1:0] w_g_inc;
   logic             w_forced;
   logic             w_load;
   logic             w_xfer;

   rr_arbiter #(.N(N)) u_arb (
      .i_req   (in_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_vld)
   );

`ifdef MUX_FORCE_SEL_EN
   assign w_forced = force_en && (r_state == ST_IDLE);
`else
   assign w_forced = 1'b0;
`endif

   always_comb begin
      w_g     = w_arb_idx;
      w_g_vld = w_arb_vld;
      w_g_oh  = w_arb_grant;
      if (r_state == ST_LOCK) begin
         w_g     = r_lock_ch;
         w_g_vld = 1'b1;
         w_g_oh  = N'(1) << r_lock_ch;
      end
`ifdef MUX_FORCE_SEL_EN
      else if (w_forced) begin
         w_g     = force_sel;
         w_g_vld = (force_sel <= c_last_idx);
         w_g_oh  = (force_sel <= c_last_idx) ? (N'(1) << force_sel) : '0;
      end
`endif
   end

   assign w_load   = !out_valid || out_ready;
   assign in_ready = (w_load && rst_n && w_g_vld) ? w_g_oh : '0;
   assign w_xfer   = w_load && rst_n && w_g_vld && in_valid[w_g];
   assign w_g_inc  = (w_g == c_last_idx) ? '0 : w_g + 1'b1;
   assign busy     = (r_state == ST_LOCK);

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_lock_nxt  = r_lock_ch;
      case (r_state)
         ST_IDLE: begin
            if (w_xfer) begin
               if (!in_last[w_g]) begin
                  w_state_nxt = ST_LOCK;
                  w_lock_nxt  = w_g;
               end else if (!w_forced) begin
                  w_ptr_nxt = w_g_inc;
               end
            end
         end
         ST_LOCK: begin
            if (w_xfer && in_last[w_g]) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = w_g_inc;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_lock_ch <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_lock_ch <= w_lock_nxt;
      end
   end

   // Output register: holds while stalled, drains to empty when nothing transfers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sel   <= '0;
      end else if (w_load) begin
         out_valid <= w_xfer;
         if (w_xfer) begin
            out_data <= in_data[w_g*WIDTH +: WIDTH];
            out_last <= in_last[w_g];
            out_sel  <= w_g;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_stream.sv
// ============================================================================
// Module   : tb_mux_rr_stream
// Brief    : Directed self-checking bench for mux_rr_stream (N=4 and N=3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux_rr_stream;

   logic         clk = 1'b0;
   logic         rst_n;

   logic [3:0]   v4, r4, l4;
   logic [255:0] d4;
   logic         ov4, ordy4, ol4, busy4;
   logic [63:0]  od4;
   logic [1:0]   os4;

   logic [2:0]   v3, r3, l3;
   logic [191:0] d3;
   logic         ov3, ordy3, ol3, busy3;
   logic [63:0]  od3;
   logic [1:0]   os3;

`ifdef MUX_FORCE_SEL_EN
   logic         fe4, fe3;
   logic [1:0]   fs4, fs3;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mux_rr_stream #(.WIDTH(64), .N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_data(d4),
      .in_last(l4), .out_valid(ov4), .out_ready(ordy4), .out_data(od4),
      .out_last(ol4), .out_sel(os4),
`ifdef MUX_FORCE_SEL_EN
      .force_en(fe4), .force_sel(fs4),
`endif
      .busy(busy4)
   );

   mux_rr_stream #(.WIDTH(64), .N(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3), .in_data(d3),
      .in_last(l3), .out_valid(ov3), .out_ready(ordy3), .out_data(od3),
      .out_last(ol3), .out_sel(os3),
`ifdef MUX_FORCE_SEL_EN
      .force_en(fe3), .force_sel(fs3),
`endif
      .busy(busy3)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      v4 = 4'hF; l4 = 4'hF; ordy4 = 1'b1;
      v3 = 3'h7; l3 = 3'h7; ordy3 = 1'b1;
      tick(); tick();
      n_tests++; if (ov4 !== 1'b0)   begin n_fail++; $display("FAIL rst_out_valid: got %b exp 0", ov4); end
      n_tests++; if (od4 !== 64'h0)  begin n_fail++; $display("FAIL rst_out_data: got %h exp 0", od4); end
      n_tests++; if (ol4 !== 1'b0)   begin n_fail++; $display("FAIL rst_out_last: got %b exp 0", ol4); end
      n_tests++; if (os4 !== 2'd0)   begin n_fail++; $display("FAIL rst_out_sel: got %0d exp 0", os4); end
      n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy4); end
      n_tests++; if (r4 !== 4'h0)    begin n_fail++; $display("FAIL rst_in_ready: got %b exp 0000", r4); end
      n_tests++; if (r3 !== 3'h0)    begin n_fail++; $display("FAIL rst_in_ready_n3: got %b exp 000", r3); end
      n_tests++; if (ov3 !== 1'b0)   begin n_fail++; $display("FAIL rst_out_valid_n3: got %b exp 0", ov3); end
      v3 = 3'h0;
   endtask

   task automatic test_round_robin;
      d4 = {64'h1003, 64'h1002, 64'h1001, 64'h1000};
      v4 = 4'hF; l4 = 4'hF; ordy4 = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         int e;
         e = i % 4;
         #1;
         n_tests++; if (r4 !== 4'(1 << e)) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b exp %b", i, r4, 4'(1 << e)); end
         tick();
         n_tests++; if (ov4 !== 1'b1 || os4 !== 2'(e)) begin n_fail++; $display("FAIL rr_sel[%0d]: got v=%b sel=%0d exp v=1 sel=%0d", i, ov4, os4, e); end
         n_tests++; if (od4 !== 64'h1000 + 64'(e)) begin n_fail++; $display("FAIL rr_data[%0d]: got %h exp %h", i, od4, 64'h1000 + 64'(e)); end
      end
   endtask

   task automatic test_packet_lock;
      v4 = 4'b0101; l4 = 4'b0001;
      d4[0 +: 64]   = 64'h1000;
      d4[128 +: 64] = 64'h2000;
      #1;
      n_tests++; if (r4 !== 4'b0100) begin n_fail++; $display("FAIL lock_ready0: got %b exp 0100", r4); end
      tick();
      n_tests++; if (os4 !== 2'd2 || od4 !== 64'h2000 || ol4 !== 1'b0 || busy4 !== 1'b1) begin n_fail++; $display("FAIL lock_beat1: got sel=%0d data=%h last=%b busy=%b exp 2 2000 0 1", os4, od4, ol4, busy4); end
      d4[128 +: 64] = 64'h2001;
      #1;
      n_tests++; if (r4 !== 4'b0100) begin n_fail++; $display("FAIL lock_ready1: got %b exp 0100", r4); end
      tick();
      n_tests++; if (os4 !== 2'd2 || od4 !== 64'h2001 || busy4 !== 1'b1) begin n_fail++; $display("FAIL lock_beat2: got sel=%0d data=%h busy=%b exp 2 2001 1", os4, od4, busy4); end
      v4[2] = 1'b0;
      #1;
      n_tests++; if (r4 !== 4'b0100) begin n_fail++; $display("FAIL lock_owner_gap_ready: got %b exp 0100", r4); end
      tick();
      n_tests++; if (ov4 !== 1'b0 || busy4 !== 1'b1) begin n_fail++; $display("FAIL lock_owner_gap: got v=%b busy=%b exp 0 1", ov4, busy4); end
      v4[2] = 1'b1; l4[2] = 1'b1; d4[128 +: 64] = 64'h2002;
      tick();
      n_tests++; if (os4 !== 2'd2 || od4 !== 64'h2002 || ol4 !== 1'b1 || busy4 !== 1'b0) begin n_fail++; $display("FAIL lock_beat3: got sel=%0d data=%h last=%b busy=%b exp 2 2002 1 0", os4, od4, ol4, busy4); end
      n_tests++; if (r4 !== 4'b0001) begin n_fail++; $display("FAIL lock_release_ready: got %b exp 0001", r4); end
      tick();
      n_tests++; if (os4 !== 2'd0 || od4 !== 64'h1000) begin n_fail++; $display("FAIL lock_next: got sel=%0d data=%h exp 0 1000", os4, od4); end
      v4 = 4'h0;
   endtask

   task automatic test_stall;
      v4 = 4'b0010; l4 = 4'hF; ordy4 = 1'b1;
      d4[64 +: 64] = 64'h1001;
      tick();
      n_tests++; if (os4 !== 2'd1 || ov4 !== 1'b1) begin n_fail++; $display("FAIL stall_load: got v=%b sel=%0d exp 1 1", ov4, os4); end
      ordy4 = 1'b0; v4 = 4'hF; d4[64 +: 64] = 64'hDEAD;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++; if (r4 !== 4'h0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b exp 0000", i, r4); end
         tick();
         n_tests++; if (ov4 !== 1'b1 || od4 !== 64'h1001 || ol4 !== 1'b1 || os4 !== 2'd1) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b data=%h last=%b sel=%0d exp 1 1001 1 1", i, ov4, od4, ol4, os4); end
      end
      ordy4 = 1'b1;
      #1;
      n_tests++; if (r4 !== 4'b0100) begin n_fail++; $display("FAIL stall_resume_ready: got %b exp 0100", r4); end
      tick();
      n_tests++; if (os4 !== 2'd2) begin n_fail++; $display("FAIL stall_resume_sel: got %0d exp 2", os4); end
      v4 = 4'h0;
      #1;
      n_tests++; if (r4 !== 4'h0) begin n_fail++; $display("FAIL idle_ready: got %b exp 0000", r4); end
      tick();
      n_tests++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL idle_drain: got %b exp 0", ov4); end
   endtask

   task automatic test_wrap_n3;
      d3 = {64'h3002, 64'h3001, 64'h3000};
      v3 = 3'b100; l3 = 3'h7; ordy3 = 1'b1;
      #1;
      n_tests++; if (r3 !== 3'b100) begin n_fail++; $display("FAIL n3_ready_ch2: got %b exp 100", r3); end
      tick();
      n_tests++; if (os3 !== 2'd2 || od3 !== 64'h3002) begin n_fail++; $display("FAIL n3_sel_ch2: got sel=%0d data=%h exp 2 3002", os3, od3); end
      v3 = 3'b011;
      #1;
      n_tests++; if (r3 !== 3'b001) begin n_fail++; $display("FAIL n3_wrap_ready: got %b exp 001", r3); end
      tick();
      n_tests++; if (os3 !== 2'd0 || od3 !== 64'h3000) begin n_fail++; $display("FAIL n3_wrap_sel: got sel=%0d data=%h exp 0 3000", os3, od3); end
      v3 = 3'b101;
      #1;
      n_tests++; if (r3 !== 3'b100) begin n_fail++; $display("FAIL n3_skip_ready: got %b exp 100", r3); end
      tick();
      v3 = 3'b110;
      #1;
      n_tests++; if (r3 !== 3'b010) begin n_fail++; $display("FAIL n3_wrap2_ready: got %b exp 010", r3); end
      tick();
      n_tests++; if (os3 !== 2'd1) begin n_fail++; $display("FAIL n3_wrap2_sel: got %0d exp 1", os3); end
      v3 = 3'h0;
      tick();
   endtask

   task automatic test_reset_midpacket;
      v4 = 4'b0010; l4 = 4'h0;
      d4[64 +: 64] = 64'h5000;
      #1;
      n_tests++; if (r4 !== 4'b0010) begin n_fail++; $display("FAIL midrst_ready: got %b exp 0010", r4); end
      tick();
      n_tests++; if (busy4 !== 1'b1 || os4 !== 2'd1) begin n_fail++; $display("FAIL midrst_lock: got busy=%b sel=%0d exp 1 1", busy4, os4); end
      rst_n = 1'b0;
      tick();
      n_tests++; if (ov4 !== 1'b0 || busy4 !== 1'b0) begin n_fail++; $display("FAIL midrst_clear: got v=%b busy=%b exp 0 0", ov4, busy4); end
      rst_n = 1'b1; v4 = 4'b0011; l4 = 4'hF;
      d4[0 +: 64] = 64'h1000;
      #1;
      n_tests++; if (r4 !== 4'b0001) begin n_fail++; $display("FAIL midrst_ptr_ready: got %b exp 0001", r4); end
      tick();
      n_tests++; if (os4 !== 2'd0 || ov4 !== 1'b1) begin n_fail++; $display("FAIL midrst_ptr_sel: got v=%b sel=%0d exp 1 0", ov4, os4); end
   endtask

`ifdef MUX_FORCE_SEL_EN
   task automatic test_force;
      fe4 = 1'b1; fs4 = 2'd3; v4 = 4'hF; l4 = 4'hF; ordy4 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (os4 !== 2'd3 || ov4 !== 1'b1) begin n_fail++; $display("FAIL force_sel[%0d]: got v=%b sel=%0d exp 1 3", i, ov4, os4); end
      end
      fe4 = 1'b0;
      #1;
      n_tests++; if (r4 !== 4'b0010) begin n_fail++; $display("FAIL force_ptr_kept: got %b exp 0010", r4); end
      v4 = 4'h0;
      fe3 = 1'b1; fs3 = 2'd3; v3 = 3'h7; l3 = 3'h7; ordy3 = 1'b1;
      #1;
      n_tests++; if (r3 !== 3'h0) begin n_fail++; $display("FAIL force_oor_ready: got %b exp 000", r3); end
      tick(); tick();
      n_tests++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL force_oor_valid: got %b exp 0", ov3); end
      fe3 = 1'b0; v3 = 3'h0;
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      v4 = '0; l4 = '0; d4 = '0; ordy4 = 1'b0;
      v3 = '0; l3 = '0; d3 = '0; ordy3 = 1'b0;
`ifdef MUX_FORCE_SEL_EN
      fe4 = 1'b0; fs4 = '0; fe3 = 1'b0; fs3 = '0;
`endif
      test_reset();
      test_round_robin();
      test_packet_lock();
      test_stall();
      test_wrap_n3();
      test_reset_midpacket();
`ifdef MUX_FORCE_SEL_EN
      test_force();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
